layer_scene_sequencer: RTL and testbench

//   Timeline controller for the HDMI demo compositor. Counts frames and walks a scene table.
//   For each scene it drives a layer-enable mask (text quadrants, sinescroll, rasterbars, stars)
//   and a global fade level, giving fade-in -> hold -> fade-out per scene.
//   All changes land at frame boundaries so a frame never tears. Sits beside the layer

---
 rtl/layer_scene_sequencer_if.sv | 30 +++
 rtl/layer_scene_sequencer.sv | 154 +++++++++++++++
 tb/tb_layer_scene_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_scene_sequencer_if.sv
// Control and output bundle between the demo timeline sequencer and its surroundings.
// Carries the frame-rate control pulses in and the registered layer/fade state out.
interface layer_scene_sequencer_if #(
    parameter int NUM_LAYERS = 7,
    parameter int NUM_SCENES = 4
);
    localparam int IDXW = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;

    // No valid/ready pair: frame_start and skip are single-cycle pulses sampled on
    // every clock, run/pause are levels, and all outputs are registered and always valid.
    logic                  frame_start;
    logic                  run;
    logic                  pause;
    logic                  skip;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [7:0]            fade_level;
    logic [IDXW-1:0]       scene_idx;
    logic                  scene_change;
    logic [1:0]            state;

    modport master (
        output frame_start, run, pause, skip,
        input  layer_en, fade_level, scene_idx, scene_change, state
    );

    modport slave (
        input  frame_start, run, pause, skip,
        output layer_en, fade_level, scene_idx, scene_change, state
    );
endinterface

// File: rtl/layer_scene_sequencer.sv
// Frame-synchronous scene timeline: walks a scene table giving each scene a
// fade-in, hold and fade-out, with layer masks swapped only on a black frame.
module layer_scene_sequencer #(
    parameter int NUM_LAYERS = 7,
    parameter int NUM_SCENES = 4,
    parameter int FRAMEW     = 12,
    parameter int FADE_STEP  = 51,
    parameter logic [NUM_SCENES*NUM_LAYERS-1:0] SCENE_MASK   = {NUM_SCENES{7'h7F}},
    parameter logic [NUM_SCENES*FRAMEW-1:0]     SCENE_FRAMES = {NUM_SCENES{12'd60}}
) (
    input logic video_clk_pix,
    input logic video_rst_n,
    layer_scene_sequencer_if.slave bus
);
    localparam int IDXW = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;
    localparam logic [7:0]      STEP     = 8'(FADE_STEP);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SCENES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FADE_IN  = 2'd1,
        S_HOLD     = 2'd2,
        S_FADE_OUT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            fade_q, fade_d;
    logic [FRAMEW-1:0]     hold_q, hold_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [NUM_LAYERS-1:0] layer_q, layer_d;
    logic                  change_q, change_d;
    logic                  skip_q, skip_d;

    logic                  tick;
    logic                  want_skip;
    logic [8:0]            fade_sum;
    logic [7:0]            fade_up;
    logic [7:0]            fade_dn;
    logic [IDXW-1:0]       idx_next;

    function automatic logic [NUM_LAYERS-1:0] mask_of(input logic [IDXW-1:0] i);
        logic [NUM_LAYERS-1:0] m;
        m = '0;
        for (int s = 0; s < NUM_SCENES; s++) begin
            if (i == IDXW'(s)) m = SCENE_MASK[s*NUM_LAYERS +: NUM_LAYERS];
        end
        return m;
    endfunction

    // Last hold count for a scene; a zero duration still holds for one tick.
    function automatic logic [FRAMEW-1:0] hold_last(input logic [IDXW-1:0] i);
        logic [FRAMEW-1:0] f;
        f = '0;
        for (int s = 0; s < NUM_SCENES; s++) begin
            if (i == IDXW'(s)) f = SCENE_FRAMES[s*FRAMEW +: FRAMEW];
        end
        return (f == '0) ? '0 : f - 1'b1;
    endfunction

    assign tick      = bus.frame_start && !bus.pause;
    assign want_skip = skip_q || bus.skip;
    assign fade_sum  = {1'b0, fade_q} + {1'b0, STEP};
    assign fade_up   = fade_sum[8] ? 8'hFF : fade_sum[7:0];
    assign fade_dn   = (fade_q > STEP) ? (fade_q - STEP) : 8'd0;
    assign idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        fade_d   = fade_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        layer_d  = layer_q;
        change_d = 1'b0;
        skip_d   = skip_q;

        if (!bus.run) begin
            state_d = S_IDLE;
            fade_d  = 8'd0;
            hold_d  = '0;
            idx_d   = '0;
            layer_d = '0;
            skip_d  = 1'b0;
        end else if (!tick) begin
            skip_d = want_skip;
        end else begin
            // Every tick consumes a pending skip, whether or not the state uses it.
            skip_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    layer_d  = mask_of('0);
                    idx_d    = '0;
                    fade_d   = 8'd0;
                    change_d = 1'b1;
                    state_d  = S_FADE_IN;
                end
                S_FADE_IN: begin
                    if (want_skip) begin
                        state_d = S_FADE_OUT;
                    end else begin
                        fade_d = fade_up;
                        if (fade_up == 8'hFF) begin
                            hold_d  = '0;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (want_skip) begin
                        state_d = S_FADE_OUT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                        if (hold_q == hold_last(idx_q)) state_d = S_FADE_OUT;
                    end
                end
                S_FADE_OUT: begin
                    fade_d = fade_dn;
                    if (fade_dn == 8'd0) begin
                        idx_d    = idx_next;
                        layer_d  = mask_of(idx_next);
                        change_d = 1'b1;
                        state_d  = S_FADE_IN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state_q  <= S_IDLE;
            fade_q   <= 8'd0;
            hold_q   <= '0;
            idx_q    <= '0;
            layer_q  <= '0;
            change_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fade_q   <= fade_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            layer_q  <= layer_d;
            change_q <= change_d;
            skip_q   <= skip_d;
        end
    end

    assign bus.layer_en     = layer_q;
    assign bus.fade_level   = fade_q;
    assign bus.scene_idx    = idx_q;
    assign bus.scene_change = change_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_layer_scene_sequencer.sv
// Bench for layer_scene_sequencer: two differently configured instances share random
// stimulus and are scored against a queue fed by a frame-level timeline model.
module tb_layer_scene_sequencer;
    localparam logic [27:0] MASK_A = {7'h11, 7'h6A, 7'h30, 7'h4F};
    localparam logic [47:0] FR_A   = {12'd3, 12'd0, 12'd5, 12'd60};
    localparam logic [20:0] MASK_B = {7'h7F, 7'h05, 7'h50};
    localparam logic [35:0] FR_B   = {12'd1, 12'd2, 12'd0};

    localparam int PH_IDLE = 0;
    localparam int PH_UP   = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_DOWN = 3;

    logic clk;
    logic rst_n;

    layer_scene_sequencer_if #(.NUM_LAYERS(7), .NUM_SCENES(4)) bus_a ();
    layer_scene_sequencer_if #(.NUM_LAYERS(7), .NUM_SCENES(3)) bus_b ();

    layer_scene_sequencer #(
        .NUM_LAYERS(7), .NUM_SCENES(4), .FRAMEW(12), .FADE_STEP(51),
        .SCENE_MASK(MASK_A), .SCENE_FRAMES(FR_A)
    ) dut_a (
        .video_clk_pix(clk), .video_rst_n(rst_n), .bus(bus_a.slave)
    );

    layer_scene_sequencer #(
        .NUM_LAYERS(7), .NUM_SCENES(3), .FRAMEW(12), .FADE_STEP(200),
        .SCENE_MASK(MASK_B), .SCENE_FRAMES(FR_B)
    ) dut_b (
        .video_clk_pix(clk), .video_rst_n(rst_n), .bus(bus_b.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timeline model, one slot per instance
    int p_step[2]     = '{51, 200};
    int p_nsc[2]      = '{4, 3};
    int p_mask[2][4]  = '{'{'h4F, 'h30, 'h6A, 'h11}, '{'h50, 'h05, 'h7F, 0}};
    int p_frames[2][4] = '{'{60, 5, 0, 3}, '{0, 2, 1, 0}};

    int m_phase[2], m_fade[2], m_held[2], m_idx[2], m_mask[2];
    bit m_sc[2], m_pend[2];

    logic [17:0] exp_qa[$];
    logic [17:0] exp_qb[$];

    int total = 0;
    int bad   = 0;

    task automatic model_reset(input int k);
        m_phase[k] = PH_IDLE; m_fade[k] = 0; m_held[k] = 0;
        m_idx[k] = 0; m_mask[k] = 0; m_sc[k] = 0; m_pend[k] = 0;
    endtask

    task automatic model_step(input int k, input bit fs, input bit r, input bit p, input bit s);
        bit want;
        int len;
        m_sc[k] = 0;
        if (!r) begin
            model_reset(k);
            return;
        end
        if (!fs || p) begin
            m_pend[k] = m_pend[k] | s;
            return;
        end
        want = m_pend[k] | s;
        m_pend[k] = 0;
        case (m_phase[k])
            PH_IDLE: begin
                m_idx[k] = 0; m_mask[k] = p_mask[k][0]; m_fade[k] = 0;
                m_sc[k] = 1; m_phase[k] = PH_UP;
            end
            PH_UP: begin
                if (want) m_phase[k] = PH_DOWN;
                else begin
                    m_fade[k] = (m_fade[k] + p_step[k] > 255) ? 255 : m_fade[k] + p_step[k];
                    if (m_fade[k] == 255) begin
                        m_held[k] = 0;
                        m_phase[k] = PH_HOLD;
                    end
                end
            end
            PH_HOLD: begin
                if (want) m_phase[k] = PH_DOWN;
                else begin
                    len = (p_frames[k][m_idx[k]] < 1) ? 1 : p_frames[k][m_idx[k]];
                    m_held[k]++;
                    if (m_held[k] >= len) m_phase[k] = PH_DOWN;
                end
            end
            default: begin
                m_fade[k] = (m_fade[k] < p_step[k]) ? 0 : m_fade[k] - p_step[k];
                if (m_fade[k] == 0) begin
                    m_idx[k] = (m_idx[k] + 1) % p_nsc[k];
                    m_mask[k] = p_mask[k][m_idx[k]];
                    m_sc[k] = 1;
                    m_phase[k] = PH_UP;
                end
            end
        endcase
    endtask

    function automatic logic [17:0] model_out(input int k);
        return {7'(m_mask[k]), 8'(m_fade[k]), 2'(m_idx[k]), 1'(m_sc[k])};
    endfunction

    // Scoreboard comparison
    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got mask=%h fade=%0d idx=%0d chg=%0b, expected mask=%h fade=%0d idx=%0d chg=%0b",
                     name, $time, act[17:11], act[10:3], act[2:1], act[0],
                     exp[17:11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    // Monitor: outputs are registered and always valid, so one entry per cycle
    always @(negedge clk) begin
        logic [17:0] e;
        if (exp_qa.size() > 0) begin
            e = exp_qa.pop_front();
            check("out_a", {bus_a.layer_en, bus_a.fade_level, bus_a.scene_idx, bus_a.scene_change}, e);
        end
        if (exp_qb.size() > 0) begin
            e = exp_qb.pop_front();
            check("out_b", {bus_b.layer_en, bus_b.fade_level, bus_b.scene_idx, bus_b.scene_change}, e);
        end
    end

    // Driver tasks
    task automatic drive(input bit fs, input bit r, input bit p, input bit s);
        bus_a.frame_start = fs; bus_a.run = r; bus_a.pause = p; bus_a.skip = s;
        bus_b.frame_start = fs; bus_b.run = r; bus_b.pause = p; bus_b.skip = s;
    endtask

    task automatic cycle(input bit fs, input bit r, input bit p, input bit s);
        drive(fs, r, p, s);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_step(k, fs, r, p, s);
        exp_qa.push_back(model_out(0));
        exp_qb.push_back(model_out(1));
    endtask

    // Asserts reset between edges and checks the outputs clear with no clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_a", {bus_a.layer_en, bus_a.fade_level, bus_a.scene_idx, bus_a.scene_change}, 18'd0);
        check("rst_b", {bus_b.layer_en, bus_b.fade_level, bus_b.scene_idx, bus_b.scene_change}, 18'd0);
        exp_qa.delete();
        exp_qb.delete();
        model_reset(0);
        model_reset(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        async_reset();

        // Continuous ticks into scene 0 fade-out, then drop run
        for (int i = 0; i < 68; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Full walk through every scene, including wrap back to scene 0
        for (int i = 0; i < 250; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

        // Async reset mid-hold, then park at hold count 10 and skip while paused
        async_reset();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, (i == 5));
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

        // Skip on the same cycle as a tick, during fade-in
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, (i == 1));
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && (exp_qa.size() > 0 || exp_qb.size() > 0); i++) @(negedge clk);
        #1;
        total++;
        if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", exp_qa.size(), exp_qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
